// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants, FSM states and datapath select encodings
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_R     = 4'd7,
        WB_I     = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_e;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_LUI, I_ADDI,
        I_ADDIU, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILLEGAL
    } instr_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;
    localparam logic [1:0] ALU_LUI   = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] DST_RT    = 2'b00;
    localparam logic [1:0] DST_RD    = 2'b01;
    localparam logic [1:0] DST_RA    = 2'b11;

    localparam logic [1:0] SRC_ALU   = 2'b00;
    localparam logic [1:0] SRC_MDR   = 2'b01;
    localparam logic [1:0] SRC_SLT   = 2'b10;
    localparam logic [1:0] SRC_PC    = 2'b11;

    localparam logic [1:0] B_RT      = 2'b00;
    localparam logic [1:0] B_FOUR    = 2'b01;
    localparam logic [1:0] B_IMM     = 2'b10;
    localparam logic [1:0] B_IMM_SH  = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct classifier
module mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] instr
);

    always_comb begin
        instr = I_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: instr = I_ADDU;
                    FN_SUBU: instr = I_SUBU;
                    FN_SLT:  instr = I_SLT;
                    FN_JR:   instr = I_JR;
                    default: instr = I_ILLEGAL;
                endcase
            end
            OP_ORI:   instr = I_ORI;
            OP_LUI:   instr = I_LUI;
            OP_ADDI:  instr = I_ADDI;
            OP_ADDIU: instr = I_ADDIU;
            OP_LW:    instr = I_LW;
            OP_SW:    instr = I_SW;
            OP_BEQ:   instr = I_BEQ;
            OP_J:     instr = I_J;
            OP_JAL:   instr = I_JAL;
            default:  instr = I_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM (MC_MEM_WAIT_EN adds memory wait states)
module multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       negative,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] reg_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ctl,
    output logic       ext_op,
    output logic [3:0] state
);

    state_e     state_q, state_d;
    instr_e     instr;
    logic [3:0] instr_bits;
    logic       ovf_q;
    logic       mem_ok;
    logic       unused_inputs;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .instr  (instr_bits)
    );

    assign instr = instr_e'(instr_bits);
    assign state = state_q;

    // negative feeds the datapath's slt flag directly; the controller only selects it
`ifdef MC_MEM_WAIT_EN
    assign mem_ok        = mem_ready;
    assign unused_inputs = negative;
`else
    assign mem_ok        = 1'b1;
    assign unused_inputs = negative ^ mem_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == EXEC_I)
                ovf_q <= overflow;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_ALU;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        reg_dst   = DST_RT;
        reg_src   = SRC_ALU;
        alu_src_a = 1'b0;
        alu_src_b = B_RT;
        alu_ctl   = ALU_ADD;
        ext_op    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
                alu_src_b = B_FOUR;
                if (mem_ok)
                    state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = B_IMM_SH;
                ext_op    = 1'b1;
                case (instr)
                    I_ADDU, I_SUBU, I_SLT:          state_d = EXEC_R;
                    I_ORI, I_LUI, I_ADDI, I_ADDIU:  state_d = EXEC_I;
                    I_LW, I_SW:                     state_d = MEM_ADDR;
                    I_BEQ:                          state_d = BRANCH;
                    I_J, I_JAL, I_JR:               state_d = JUMP;
                    default:                        state_d = FETCH;
                endcase
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctl   = (instr == I_ADDU) ? ALU_ADD : ALU_SUB;
                state_d   = WB_R;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = B_IMM;
                case (instr)
                    I_ORI:   alu_ctl = ALU_OR;
                    I_LUI:   alu_ctl = ALU_LUI;
                    default: alu_ctl = ALU_ADD;
                endcase
                ext_op  = (instr == I_ADDI) || (instr == I_ADDIU);
                state_d = WB_I;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = B_IMM;
                ext_op    = 1'b1;
                state_d   = (instr == I_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ok)
                    state_d = WB_MEM;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ok)
                    state_d = FETCH;
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = DST_RD;
                reg_src   = (instr == I_SLT) ? SRC_SLT : SRC_ALU;
                state_d   = FETCH;
            end
            WB_I: begin
                // addi traps on signed overflow, so the write is dropped
                reg_write = !((instr == I_ADDI) && ovf_q);
                state_d   = FETCH;
            end
            WB_MEM: begin
                reg_write = 1'b1;
                reg_src   = SRC_MDR;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctl   = ALU_SUB;
                pc_src    = PC_BRANCH;
                pc_write  = zero;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = (instr == I_JR) ? PC_RS : PC_JUMP;
                if (instr == I_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = DST_RA;
                    reg_src   = SRC_PC;
                end
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // an in-flight instruction is silenced the moment reset asserts
        if (!rst_n) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, negative, overflow, mem_ready;
    logic       ir_write, pc_write, iord, mem_read, mem_write, reg_write, alu_src_a, ext_op;
    logic [1:0] pc_src, reg_dst, reg_src, alu_src_b, alu_ctl;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    localparam int N_ADDU = 0, N_SUBU = 1, N_SLT = 2, N_JR = 3, N_ORI = 4, N_LUI = 5, N_ADDI = 6;
    localparam int N_ADDIU = 7, N_LW = 8, N_SW = 9, N_BEQ = 10, N_J = 11, N_JAL = 12, N_ILL = 13;
    string names [14] = '{"addu", "subu", "slt", "jr", "ori", "lui", "addi",
                          "addiu", "lw", "sw", "beq", "j", "jal", "illegal"};

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .negative(negative), .overflow(overflow), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .reg_src(reg_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .ext_op(ext_op), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pick_enc(input int ins, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (ins)
            N_ADDU:  begin op = 6'h00; fn = 6'h21; end
            N_SUBU:  begin op = 6'h00; fn = 6'h23; end
            N_SLT:   begin op = 6'h00; fn = 6'h2a; end
            N_JR:    begin op = 6'h00; fn = 6'h08; end
            N_ORI:   op = 6'h0d;
            N_LUI:   op = 6'h0f;
            N_ADDI:  op = 6'h08;
            N_ADDIU: op = 6'h09;
            N_LW:    op = 6'h23;
            N_SW:    op = 6'h2b;
            N_BEQ:   op = 6'h04;
            N_J:     op = 6'h02;
            N_JAL:   op = 6'h03;
            default: begin
                case ($urandom_range(0, 2))
                    0: op = 6'h3f;
                    1: begin
                        op = 6'h00;
                        if (fn == 6'h21 || fn == 6'h23 || fn == 6'h2a || fn == 6'h08)
                            fn = 6'h3f;
                    end
                    default: op = 6'($urandom_range(16, 34));
                endcase
            end
        endcase
    endtask

    function automatic int n_phases(input int ins);
        if (ins == N_ILL) return 2;
        if (ins == N_LW) return 5;
        if (ins == N_BEQ || ins == N_J || ins == N_JAL || ins == N_JR) return 3;
        return 4;
    endfunction

    function automatic state_e phase_of(input int ins, input int k);
        if (k == 0) return FETCH;
        if (k == 1) return DECODE;
        case (ins)
            N_ADDU, N_SUBU, N_SLT:         return (k == 2) ? EXEC_R : WB_R;
            N_ORI, N_LUI, N_ADDI, N_ADDIU: return (k == 2) ? EXEC_I : WB_I;
            N_LW:  return (k == 2) ? MEM_ADDR : (k == 3) ? MEM_RD : WB_MEM;
            N_SW:  return (k == 2) ? MEM_ADDR : MEM_WR;
            N_BEQ: return BRANCH;
            default: return JUMP;
        endcase
    endfunction

    // expected output bundle and don't-care mask for one phase of one instruction
    task automatic model(input int ins, input state_e ph, input logic zv, input logic ov,
                         output logic [21:0] ev, output logic [21:0] em);
        logic irw, pcw, io, mr, mw, rw, sa, ex;
        logic [1:0] ps, rd, rs, sb, ac;
        logic m_ps, m_io, m_rd, m_rs, m_sa, m_sb, m_ac, m_ex;
        {irw, pcw, io, mr, mw, rw, sa, ex} = '0;
        {ps, rd, rs, sb, ac} = '0;
        {m_ps, m_io, m_rd, m_rs, m_sa, m_sb, m_ac, m_ex} = '0;
        case (ph)
            FETCH: begin
                mr = 1; irw = 1; pcw = 1; sb = 2'b01;
                {m_ps, m_io, m_sa, m_sb, m_ac} = '1;
            end
            DECODE: begin
                sb = 2'b11; ex = 1;
                {m_sa, m_sb, m_ac, m_ex} = '1;
            end
            EXEC_R: begin
                sa = 1; ac = (ins == N_ADDU) ? 2'b00 : 2'b01;
                {m_sa, m_sb, m_ac} = '1;
            end
            EXEC_I: begin
                sa = 1; sb = 2'b10;
                ac = (ins == N_ORI) ? 2'b10 : (ins == N_LUI) ? 2'b11 : 2'b00;
                ex = (ins == N_ADDI || ins == N_ADDIU);
                {m_sa, m_sb, m_ac, m_ex} = '1;
            end
            MEM_ADDR: begin
                sa = 1; sb = 2'b10; ex = 1;
                {m_sa, m_sb, m_ac, m_ex} = '1;
            end
            MEM_RD: begin mr = 1; io = 1; m_io = 1; end
            MEM_WR: begin mw = 1; io = 1; m_io = 1; end
            WB_R: begin
                rw = 1; rd = 2'b01; rs = (ins == N_SLT) ? 2'b10 : 2'b00;
                {m_rd, m_rs} = '1;
            end
            WB_I: begin
                rw = !(ins == N_ADDI && ov);
                {m_rd, m_rs} = '1;
            end
            WB_MEM: begin
                rw = 1; rs = 2'b01;
                {m_rd, m_rs} = '1;
            end
            BRANCH: begin
                sa = 1; ac = 2'b01; ps = 2'b01; pcw = zv;
                {m_sa, m_sb, m_ac, m_ps} = '1;
            end
            default: begin
                pcw = 1; ps = (ins == N_JR) ? 2'b11 : 2'b10; m_ps = 1;
                if (ins == N_JAL) begin
                    rw = 1; rd = 2'b11; rs = 2'b11;
                    {m_rd, m_rs} = '1;
                end
            end
        endcase
        ev = {irw, pcw, ps, io, mr, mw, rw, rd, rs, sa, sb, ac, ex, 4'(ph)};
        em = {1'b1, 1'b1, {2{m_ps}}, m_io, 1'b1, 1'b1, 1'b1, {2{m_rd}}, {2{m_rs}},
              m_sa, {2{m_sb}}, {2{m_ac}}, m_ex, 4'hf};
    endtask

    function automatic logic [21:0] dut_bundle();
        return {ir_write, pc_write, pc_src, iord, mem_read, mem_write, reg_write,
                reg_dst, reg_src, alu_src_a, alu_src_b, alu_ctl, ext_op, state};
    endfunction

    task automatic run_instr(input int ins, input logic [5:0] op, input logic [5:0] fn,
                             input logic zv, input logic ov);
        logic [21:0] ev, em;
        state_e ph;
        opcode = op;
        funct  = fn;
        for (int k = 0; k < n_phases(ins); k++) begin
            ph       = phase_of(ins, k);
            zero     = (ph == BRANCH) ? zv : 1'($urandom);
            overflow = (ph == EXEC_I) ? ov : 1'($urandom);
            negative = 1'($urandom);
`ifdef MC_MEM_WAIT_EN
            mem_ready = 1'b1;
`else
            mem_ready = 1'($urandom);
`endif
            @(negedge clk);
            model(ins, ph, zv, ov, ev, em);
            check_eq($sformatf("%s.%s", names[ins], ph.name()), 32'(dut_bundle() & em), 32'(ev & em));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        int ins, cyc, writes, lows;
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 0; negative = 0; overflow = 0; mem_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_state", 32'(state), 32'(FETCH));
        check_eq("reset_strobes", 32'({ir_write, pc_write, mem_read, mem_write, reg_write}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr(N_ADDU, 6'h00, 6'h21, 0, 0);
        run_instr(N_BEQ, 6'h04, 6'h00, 1, 0);
        run_instr(N_BEQ, 6'h04, 6'h00, 0, 0);
        run_instr(N_ADDI, 6'h08, 6'h00, 0, 1);
        run_instr(N_ADDI, 6'h08, 6'h00, 0, 0);
        run_instr(N_ADDIU, 6'h09, 6'h00, 0, 1);
        run_instr(N_JAL, 6'h03, 6'h00, 0, 0);
        run_instr(N_ILL, 6'h3f, 6'h00, 0, 0);

        // abort a load in MEM_RD with a reset pulse
        opcode = 6'h23; mem_ready = 1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check_eq("abort_pre_state", 32'(state), 32'(MEM_RD));
        rst_n = 1'b0;
        #1;
        check_eq("abort_state", 32'(state), 32'(FETCH));
        check_eq("abort_strobes", 32'({ir_write, pc_write, mem_read, mem_write, reg_write}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef MC_MEM_WAIT_EN
        opcode = 6'h23; cyc = 0; writes = 0; lows = 0;
        do begin
            if (state == MEM_RD && lows < 2) begin mem_ready = 0; lows++; end
            else mem_ready = 1;
            @(negedge clk);
            if (reg_write) writes++;
            cyc++;
            @(posedge clk); #1;
        end while (state != FETCH && cyc < 20);
        mem_ready = 1;
        check_eq("wait_lw_cycles", 32'(cyc), 7);
        check_eq("wait_lw_writes", 32'(writes), 1);
`endif

        for (int n = 0; n < 300; n++) begin
            ins = $urandom_range(0, 13);
            pick_enc(ins, op, fn);
            run_instr(ins, op, fn, 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
